// File: rtl/ascon_permutation_engine_if.sv
// Request/response bundle between the ASCON permutation engine and its controller.
interface ascon_permutation_engine_if;
    logic         start_i;
    logic         src_ext_i;
    logic [319:0] state_i;
    logic [63:0]  data_i;
    logic [127:0] key_i;
    logic [3:0]   nrounds_i;
    logic         xor_data_i;
    logic         xor_key_begin_i;
    logic         xor_key_end_i;
    logic         xor_lsb_end_i;
    logic         busy_o;
    logic         done_o;
    logic [319:0] state_o;
    logic [63:0]  C_o;

    modport master (
        output start_i, src_ext_i, state_i, data_i, key_i, nrounds_i,
               xor_data_i, xor_key_begin_i, xor_key_end_i, xor_lsb_end_i,
        input  busy_o, done_o, state_o, C_o
    );

    modport slave (
        input  start_i, src_ext_i, state_i, data_i, key_i, nrounds_i,
               xor_data_i, xor_key_begin_i, xor_key_end_i, xor_lsb_end_i,
        output busy_o, done_o, state_o, C_o
    );
endinterface

// File: rtl/ascon_permutation_engine.sv
// Self-sequencing ASCON p^a / p^b permutation: UNROLL rounds per clock,
// optional data/key/domain XORs around the round sequence, start/done handshake.
module ascon_permutation_engine #(
    parameter int UNROLL = 1
) (
    input logic                        clock_i,
    input logic                        resetb_i,
    ascon_permutation_engine_if.slave  eng_if
);
    typedef logic [319:0] type_state;
    typedef enum logic {IDLE, RUN} fsm_e;

    fsm_e        fsm_q, fsm_d;
    type_state   state_q, state_d;
    type_state   s0, s_run;
    logic [63:0] c_q, c_d;
    logic [3:0]  round_q, round_d;
    logic        done_q, done_d;
    logic        key_end_q, key_end_d;
    logic        lsb_end_q, lsb_end_d;
    logic [3:0]  neff;

    function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // One full round: constant addition, bitsliced S-box, linear diffusion.
    function automatic type_state ascon_round(input type_state s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x2[7:0] = x2[7:0] ^ {4'd15 - r, r};
        x0 = x0 ^ x4;  x4 = x4 ^ x3;  x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1;  x1 = x1 ^ t2;  x2 = x2 ^ t3;  x3 = x3 ^ t4;  x4 = x4 ^ t0;
        x1 = x1 ^ x0;  x0 = x0 ^ x4;  x3 = x3 ^ x2;  x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic type_state end_xor(input type_state s, input logic [127:0] key,
                                          input logic key_en, input logic lsb_en);
        type_state t;
        t = s;
        if (key_en) t[127:0] = t[127:0] ^ key;
        if (lsb_en) t[0] = ~t[0];
        return t;
    endfunction

    assign neff = (eng_if.nrounds_i > 4'd12) ? 4'd12 : eng_if.nrounds_i;

    // NOTE: every variable written in always_comb gets a value before any
    // conditional path, so no path can leave it unassigned and infer a latch.
    always_comb begin
        s0 = eng_if.src_ext_i ? eng_if.state_i : state_q;
        if (eng_if.xor_data_i)      s0[319:256] = s0[319:256] ^ eng_if.data_i;
        if (eng_if.xor_key_begin_i) s0[255:128] = s0[255:128] ^ eng_if.key_i;
    end

    // Stages whose round index would pass 11 leave the state untouched.
    always_comb begin
        s_run = state_q;
        for (int i = 0; i < UNROLL; i++) begin
            if (int'(round_q) + i < 12) s_run = ascon_round(s_run, round_q + 4'(i));
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        c_d       = c_q;
        round_d   = round_q;
        done_d    = 1'b0;
        key_end_d = key_end_q;
        lsb_end_d = lsb_end_q;
        case (fsm_q)
            IDLE: begin
                if (eng_if.start_i) begin
                    c_d       = s0[319:256];
                    key_end_d = eng_if.xor_key_end_i;
                    lsb_end_d = eng_if.xor_lsb_end_i;
                    if (neff == 4'd0) begin
                        state_d = end_xor(s0, eng_if.key_i, eng_if.xor_key_end_i,
                                          eng_if.xor_lsb_end_i);
                        done_d  = 1'b1;
                    end else begin
                        state_d = s0;
                        round_d = 4'd12 - neff;
                        fsm_d   = RUN;
                    end
                end
            end
            RUN: begin
                if (int'(round_q) + UNROLL >= 12) begin
                    state_d = end_xor(s_run, eng_if.key_i, key_end_q, lsb_end_q);
                    round_d = 4'd12;
                    done_d  = 1'b1;
                    fsm_d   = IDLE;
                end else begin
                    state_d = s_run;
                    round_d = round_q + 4'(UNROLL);
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q     <= IDLE;
            state_q   <= '0;
            c_q       <= '0;
            round_q   <= '0;
            done_q    <= 1'b0;
            key_end_q <= 1'b0;
            lsb_end_q <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            state_q   <= state_d;
            c_q       <= c_d;
            round_q   <= round_d;
            done_q    <= done_d;
            key_end_q <= key_end_d;
            lsb_end_q <= lsb_end_d;
        end
    end

    assign eng_if.busy_o  = (fsm_q == RUN);
    assign eng_if.done_o  = done_q;
    assign eng_if.state_o = state_q;
    assign eng_if.C_o     = c_q;
endmodule

// File: tb/tb_ascon_permutation_engine.sv
// Runs five engines (UNROLL 1,2,3,4,6) in lockstep against a table-driven ASCON model.
module tb_ascon_permutation_engine;
    logic         clock = 1'b0;
    logic         resetb = 1'b0;
    logic [4:0]   start_v = '0;
    logic         src_ext = 1'b0;
    logic [319:0] state_in = '0;
    logic [63:0]  data_in = '0;
    logic [127:0] key_in = '0;
    logic [3:0]   nrounds = '0;
    logic         f_data = 1'b0, f_kbeg = 1'b0, f_kend = 1'b0, f_lsb = 1'b0;

    logic [319:0] state_v [5];
    logic [63:0]  c_v [5];
    logic [4:0]   busy_v, done_v;

    int n_checks = 0;
    int n_pass   = 0;

    int           lat [5];
    int           pulses [5];
    logic [63:0]  c_first [5];
    logic [319:0] st_done [5];
    logic [4:0]   busy_first;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int U = (g == 4) ? 6 : g + 1;
        ascon_permutation_engine_if bus ();
        assign bus.start_i         = start_v[g];
        assign bus.src_ext_i       = src_ext;
        assign bus.state_i         = state_in;
        assign bus.data_i          = data_in;
        assign bus.key_i           = key_in;
        assign bus.nrounds_i       = nrounds;
        assign bus.xor_data_i      = f_data;
        assign bus.xor_key_begin_i = f_kbeg;
        assign bus.xor_key_end_i   = f_kend;
        assign bus.xor_lsb_end_i   = f_lsb;
        assign state_v[g] = bus.state_o;
        assign c_v[g]     = bus.C_o;
        assign busy_v[g]  = bus.busy_o;
        assign done_v[g]  = bus.done_o;
        ascon_permutation_engine #(.UNROLL(U)) dut (
            .clock_i  (clock),
            .resetb_i (resetb),
            .eng_if   (bus)
        );
    end

    // ---------------- reference model ----------------
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    function automatic int unroll_of(input int g);
        return (g == 4) ? 6 : g + 1;
    endfunction

    function automatic int exp_lat(input int n, input int u);
        int ne;
        ne = (n > 12) ? 12 : n;
        return (ne + u - 1) / u;
    endfunction

    function automatic logic [63:0] rot_right(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic logic [319:0] model_round(input logic [319:0] s, input int r);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  col;
        for (int i = 0; i < 5; i++) x[i] = s[64*(4-i) +: 64];
        x[2] = x[2] ^ 64'((15 - r) * 16 + r);
        for (int b = 0; b < 64; b++) begin
            col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
            col = SBOX[col];
            for (int i = 0; i < 5; i++) y[i][b] = col[4-i];
        end
        for (int i = 0; i < 5; i++) begin
            y[i] = y[i] ^ rot_right(y[i], ROT_A[i]) ^ rot_right(y[i], ROT_B[i]);
            s[64*(4-i) +: 64] = y[i];
        end
        return s;
    endfunction

    task automatic model_op(input logic [319:0] s_in, input logic [63:0] d, input logic [127:0] k,
                            input int n, input bit xd, input bit xkb, input bit xke, input bit xle,
                            output logic [319:0] s_out, output logic [63:0] c_out);
        logic [319:0] s;
        int ne;
        ne = (n > 12) ? 12 : n;
        s = s_in;
        if (xd)  s[319:256] = s[319:256] ^ d;
        if (xkb) s[255:128] = s[255:128] ^ k;
        c_out = s[319:256];
        for (int r = 12 - ne; r < 12; r++) s = model_round(s, r);
        if (xke) s[127:0] = s[127:0] ^ k;
        if (xle) s[0] = ~s[0];
        s_out = s;
    endtask

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Drives one operation into all engines and records what each reports.
    task automatic launch(input logic [319:0] s, input bit ext, input logic [63:0] d,
                          input logic [127:0] k, input logic [3:0] n, input bit xd, input bit xkb,
                          input bit xke, input bit xle, input int poke);
        @(negedge clock);
        state_in = s; src_ext = ext; data_in = d; key_in = k; nrounds = n;
        f_data = xd; f_kbeg = xkb; f_kend = xke; f_lsb = xle;
        start_v = '1;
        for (int g = 0; g < 5; g++) begin
            lat[g] = -1; pulses[g] = 0; st_done[g] = '0;
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge clock);
            for (int g = 0; g < 5; g++) begin
                if (done_v[g]) begin
                    pulses[g]++;
                    if (lat[g] < 0) begin
                        lat[g] = c;
                        st_done[g] = state_v[g];
                    end
                end
            end
            if (c == 0) begin
                for (int g = 0; g < 5; g++) c_first[g] = c_v[g];
                busy_first = busy_v;
            end
            start_v = (c == poke) ? 5'h1f : 5'h00;
            if (c == poke) state_in = ~s;
        end
        start_v = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetb = 1'b0;
        repeat (3) @(negedge clock);
        for (int g = 0; g < 5; g++) begin
            n_checks++;
            if (state_v[g] !== '0 || c_v[g] !== '0 || busy_v[g] !== 1'b0 || done_v[g] !== 1'b0)
                $display("FAIL reset_hold U=%0d: state=%h C=%h busy=%b done=%b, required all zero",
                         unroll_of(g), state_v[g], c_v[g], busy_v[g], done_v[g]);
            else n_pass++;
        end
        resetb = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            for (int g = 0; g < 5; g++) begin
                n_checks++;
                if (state_v[g] !== '0 || c_v[g] !== '0 || busy_v[g] !== 1'b0 || done_v[g] !== 1'b0)
                    $display("FAIL reset_idle U=%0d cyc%0d: state=%h C=%h busy=%b done=%b, required all zero",
                             unroll_of(g), c, state_v[g], c_v[g], busy_v[g], done_v[g]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_data_xor();
        logic [319:0] s, exp_s;
        logic [63:0]  exp_c;
        s = {64'h4608da0e76fcee25, 64'h876f2d998dd3ed21, 64'h5d5b8b59b7ac16ee,
             64'he23c656f97f63dc8, 64'h3e09499302483746};
        model_op(s, 64'h436F6E636576657A, '0, 6, 1, 0, 0, 0, exp_s, exp_c);
        launch(s, 1, 64'h436F6E636576657A, '0, 4'd6, 1, 0, 0, 0, -1);
        for (int g = 0; g < 5; g++) begin
            n_checks++;
            if (c_first[g] !== 64'h0567B46D138A8B5F)
                $display("FAIL data_xor_C U=%0d: got %h, required 0567b46d138a8b5f", unroll_of(g), c_first[g]);
            else n_pass++;
            n_checks++;
            if (lat[g] !== exp_lat(6, unroll_of(g)) || pulses[g] !== 1)
                $display("FAIL data_xor_latency U=%0d: got %0d (pulses %0d), required %0d (1 pulse)",
                         unroll_of(g), lat[g], pulses[g], exp_lat(6, unroll_of(g)));
            else n_pass++;
            n_checks++;
            if (st_done[g] !== exp_s)
                $display("FAIL data_xor_state U=%0d: got %h, required %h", unroll_of(g), st_done[g], exp_s);
            else n_pass++;
        end
    endtask

    task automatic test_n0_key();
        logic [319:0] exp_s;
        exp_s = {64'h0, 64'h0001020304050607, 64'h08090A0B0C0D0E0F,
                 64'h0001020304050607, 64'h08090A0B0C0D0E0E};
        launch('0, 1, '0, 128'h000102030405060708090A0B0C0D0E0F, 4'd0, 0, 1, 1, 1, -1);
        for (int g = 0; g < 5; g++) begin
            n_checks++;
            if (lat[g] !== 0 || pulses[g] !== 1 || busy_first[g] !== 1'b0)
                $display("FAIL n0_timing U=%0d: lat %0d pulses %0d busy %b, required lat 0, 1 pulse, busy 0",
                         unroll_of(g), lat[g], pulses[g], busy_first[g]);
            else n_pass++;
            n_checks++;
            if (st_done[g] !== exp_s || c_first[g] !== 64'h0)
                $display("FAIL n0_state U=%0d: got %h C=%h, required %h C=0",
                         unroll_of(g), st_done[g], c_first[g], exp_s);
            else n_pass++;
        end
    endtask

    task automatic test_unroll_equiv();
        int nlist [6] = '{6, 8, 12, 15, 3, 12};
        logic [319:0] s, exp_s;
        logic [63:0]  d, exp_c;
        logic [127:0] k;
        bit xd, xkb, xke, xle;
        for (int t = 0; t < 6; t++) begin
            s = rand320();
            d = {$urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            xd = 1'($urandom); xkb = 1'($urandom); xke = 1'($urandom); xle = 1'($urandom);
            model_op(s, d, k, nlist[t], xd, xkb, xke, xle, exp_s, exp_c);
            launch(s, 1, d, k, 4'(nlist[t]), xd, xkb, xke, xle, -1);
            for (int g = 0; g < 5; g++) begin
                n_checks++;
                if (lat[g] !== exp_lat(nlist[t], unroll_of(g)) || pulses[g] !== 1 || busy_first[g] !== 1'b1)
                    $display("FAIL unroll_latency n=%0d U=%0d: lat %0d pulses %0d busy %b, required lat %0d, 1 pulse, busy 1",
                             nlist[t], unroll_of(g), lat[g], pulses[g], busy_first[g], exp_lat(nlist[t], unroll_of(g)));
                else n_pass++;
                n_checks++;
                if (st_done[g] !== exp_s || c_first[g] !== exp_c)
                    $display("FAIL unroll_state n=%0d U=%0d: got %h C=%h, required %h C=%h",
                             nlist[t], unroll_of(g), st_done[g], c_first[g], exp_s, exp_c);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [319:0] s, exp1, exp2;
        logic [63:0]  d, c1, c2;
        int nd [5];
        int t1 [5];
        int t2 [5];
        logic [319:0] s1 [5];
        logic [319:0] s2 [5];
        s = rand320();
        d = {$urandom, $urandom};
        model_op(s, d, '0, 12, 1, 0, 0, 0, exp1, c1);
        model_op(exp1, d, '0, 12, 1, 0, 0, 0, exp2, c2);
        @(negedge clock);
        state_in = s; src_ext = 1'b1; data_in = d; key_in = '0; nrounds = 4'd12;
        f_data = 1'b1; f_kbeg = 1'b0; f_kend = 1'b0; f_lsb = 1'b0;
        start_v = '1;
        for (int g = 0; g < 5; g++) begin
            nd[g] = 0; t1[g] = -1; t2[g] = -1; s1[g] = '0; s2[g] = '0;
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            start_v = '0;
            if (c == 0) src_ext = 1'b0;
            for (int g = 0; g < 5; g++) begin
                if (done_v[g]) begin
                    nd[g]++;
                    if (nd[g] == 1) begin
                        t1[g] = c; s1[g] = state_v[g]; start_v[g] = 1'b1;
                    end else if (nd[g] == 2) begin
                        t2[g] = c; s2[g] = state_v[g];
                    end
                end
            end
        end
        start_v = '0;
        for (int g = 0; g < 5; g++) begin
            n_checks++;
            if (t1[g] !== exp_lat(12, unroll_of(g)) || t2[g] !== 2 * exp_lat(12, unroll_of(g)) + 1 || nd[g] !== 2)
                $display("FAIL chain_timing U=%0d: done at %0d and %0d (%0d pulses), required %0d and %0d (2 pulses)",
                         unroll_of(g), t1[g], t2[g], nd[g], exp_lat(12, unroll_of(g)), 2 * exp_lat(12, unroll_of(g)) + 1);
            else n_pass++;
            n_checks++;
            if (s1[g] !== exp1 || s2[g] !== exp2)
                $display("FAIL chain_state U=%0d: got %h / %h, required %h / %h",
                         unroll_of(g), s1[g], s2[g], exp1, exp2);
            else n_pass++;
        end
    endtask

    task automatic test_start_while_busy();
        logic [319:0] s, exp_s;
        logic [63:0]  d, exp_c;
        s = rand320();
        d = {$urandom, $urandom};
        model_op(s, d, '0, 12, 1, 0, 0, 1, exp_s, exp_c);
        launch(s, 1, d, '0, 4'd12, 1, 0, 0, 1, 1);
        for (int g = 0; g < 5; g++) begin
            n_checks++;
            if (lat[g] !== exp_lat(12, unroll_of(g)) || pulses[g] !== 1 || st_done[g] !== exp_s)
                $display("FAIL busy_start U=%0d: lat %0d pulses %0d state %h, required lat %0d, 1 pulse, state %h",
                         unroll_of(g), lat[g], pulses[g], st_done[g], exp_lat(12, unroll_of(g)), exp_s);
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        logic [319:0] s, exp_s;
        logic [63:0]  d, exp_c;
        @(negedge clock);
        state_in = rand320(); src_ext = 1'b1; nrounds = 4'd12;
        f_data = 1'b0; f_kbeg = 1'b0; f_kend = 1'b0; f_lsb = 1'b0;
        start_v = '1;
        @(negedge clock);
        start_v = '0;
        repeat (4) @(negedge clock);
        resetb = 1'b0;
        #1;
        for (int g = 0; g < 5; g++) begin
            n_checks++;
            if (state_v[g] !== '0 || c_v[g] !== '0 || busy_v[g] !== 1'b0 || done_v[g] !== 1'b0)
                $display("FAIL abort_clear U=%0d: state=%h C=%h busy=%b done=%b, required all zero",
                         unroll_of(g), state_v[g], c_v[g], busy_v[g], done_v[g]);
            else n_pass++;
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            n_checks++;
            if (done_v !== 5'h00 || busy_v !== 5'h00)
                $display("FAIL abort_quiet cyc%0d: done=%b busy=%b, required 00000", c, done_v, busy_v);
            else n_pass++;
        end
        resetb = 1'b1;
        s = rand320();
        d = {$urandom, $urandom};
        model_op(s, d, '0, 8, 1, 0, 0, 0, exp_s, exp_c);
        launch(s, 1, d, '0, 4'd8, 1, 0, 0, 0, -1);
        for (int g = 0; g < 5; g++) begin
            n_checks++;
            if (lat[g] !== exp_lat(8, unroll_of(g)) || st_done[g] !== exp_s)
                $display("FAIL abort_rerun U=%0d: lat %0d state %h, required lat %0d state %h",
                         unroll_of(g), lat[g], st_done[g], exp_lat(8, unroll_of(g)), exp_s);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_data_xor();
        test_n0_key();
        test_unroll_equiv();
        test_back_to_back();
        test_start_while_busy();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ascon_permutation_engine.md
Name: ascon_permutation_engine

Overview:
Parametrised, self-sequencing ASCON permutation core for the ascon128 datapath.
- Holds the 320-bit state, runs p^a or p^b with an internal round counter, and applies UNROLL rounds per clock.
- Applies the optional data, key and domain-separation XORs around the round sequence and reports completion with a start/done handshake.
- The control FSM no longer supplies round indices; it only issues start and reads back state_o/C_o.

Parameters:
UNROLL, 1, rounds applied per clock; legal values 1, 2, 3, 4, 6.

Ports:
clock_i  in  1  system clock, rising edge.
resetb_i  in  1  asynchronous active-low reset.
start_i  in  1  launch request; sampled only in IDLE.
src_ext_i  in  1  1: load state_i; 0: continue from internal state register.
state_i  in  320 (type_state)  external input state x0..x4.
data_i  in  64  block XORed into x0 before the rounds.
key_i  in  128  key K.
nrounds_i  in  4  number of rounds n.
xor_data_i  in  1  enable the data XOR before the rounds.
xor_key_begin_i  in  1  before the rounds: x1||x2 ^= K.
xor_key_end_i  in  1  after the last round: x3||x4 ^= K.
xor_lsb_end_i  in  1  after the last round: x4 ^= 1.
busy_o  out  1  high while rounds are pending.
done_o  out  1  one-cycle completion pulse.
state_o  out  320 (type_state)  state register.
C_o  out  64  x0 captured after the data XOR (ciphertext/keystream).

Behaviour:
- Reset (asynchronous, resetb_i=0):
  - state register, C_o, round counter := 0.
  - busy_o = 0, done_o = 0, FSM = IDLE.
  - Reset mid-operation aborts immediately; no done_o is produced.
- Effective rounds: neff = min(nrounds_i, 12), sampled at start.
- Round index r runs from 12-neff up to 11. The round constant is c_r = ((15-r)<<4) | r, XORed into the low byte of x2.
- Each round is constant addition, then the ASCON 5-bit S-box, then linear diffusion:
  - x0 uses rotations 19 and 28.
  - x1 uses rotations 61 and 39.
  - x2 uses rotations 1 and 6.
  - x3 uses rotations 10 and 17.
  - x4 uses rotations 7 and 41.
- FSM IDLE, on a clock edge with start_i=1:
  - S0 = src_ext_i ? state_i : state register.
  - Apply the data XOR, then the begin key XOR, to S0.
  - C_o := x0 of the result. C_o updates only at start and holds until the next start.
  - If neff=0: apply the end XORs in the same edge, stay IDLE, done_o=1 next cycle.
  - Otherwise: state register := result, r := 12-neff, busy_o=1, go to RUN.
- FSM RUN, each clock edge:
  - k = min(UNROLL, 12-r) rounds are applied.
  - The unrolled stages beyond k pass the state through unchanged.
  - r := r+k.
  - When r reaches 12: apply the enabled end XORs in the same edge, go to IDLE, busy_o=0, done_o=1 for exactly one cycle.
- Latency: done_o asserts ceil(neff/UNROLL) cycles after the start cycle. Examples:
  - UNROLL=1, n=12: 12 cycles.
  - UNROLL=4, n=6: 2 cycles (4 rounds, then 2).
- start_i while busy_o=1: ignored; no queueing.
- start_i in the same cycle as done_o is accepted, so back-to-back operations are allowed.
- Inputs other than start_i and the control/data inputs are only sampled at the start edge. key_i must be held stable until done_o when xor_key_end_i is set.
- state_o is valid in the cycle done_o is high and is held until the next start.

Test Plan:
- Reset/idle:
  - Hold resetb_i=0 → state_o=0, C_o=0, busy_o=0, done_o=0.
  - Release reset with start_i=0 for 5 cycles → all outputs unchanged.
- Data XOR:
  - src_ext_i=1, state_i x0..x4 = 4608da0e76fcee25, 876f2d998dd3ed21, 5d5b8b59b7ac16ee, e23c656f97f63dc8, 3e09499302483746.
  - data_i=436F6E636576657A, xor_data_i=1, n=6.
  - Required: C_o = 0567B46D138A8B5F one cycle after start; done_o after 6 cycles (UNROLL=1); state_o equals the golden p^6 model.
- n=0 key path:
  - state_i=0, key_i=000102030405060708090A0B0C0D0E0F, both key XORs and the LSB XOR enabled.
  - Required, next cycle: x1=x3=0001020304050607, x2=08090A0B0C0D0E0F, x4=08090A0B0C0D0E0E, x0=0; done_o=1.
- Unroll equivalence:
  - Random state, n ∈ {6, 8, 12}, UNROLL ∈ {1, 2, 3, 4, 6}.
  - Required: identical state_o for all UNROLL values; done_o delays of 12, 6, 4, 3, 2 cycles for n=12.
- Chaining/collisions:
  - p^12 with src_ext_i=1, then start with src_ext_i=0 in the done_o cycle → second run continues from the first result.
  - start_i pulsed mid-run → ignored.
- Abort: drop resetb_i in round 5 of p^12 → immediate zero state, no done_o; a subsequent run is correct.
